// File: rtl/uart_frame_packer.sv
// Decimating sample FIFO feeding a checksummed byte framer for the UART link.
// Optional FRAME_SEQ_EN inserts an 8-bit frame sequence byte after the header.
module uart_frame_packer #(
  parameter int unsigned DECIM      = 4,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  HEADER     = 8'hA5
) (
  input  logic        clk_i,
  input  logic        rst_n,
  input  logic [15:0] sample_i,
  input  logic        sample_vld_i,
  output logic [7:0]  byte_o,
  output logic        byte_vld_o,
  input  logic        byte_rdy_i,
  output logic        fifo_full_o,
  output logic [15:0] drop_cnt_o
);

  localparam int unsigned DW  = 16;
  localparam int unsigned AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned DCW = (DECIM > 1) ? $clog2(DECIM) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
`ifdef FRAME_SEQ_EN
    S_SEQ,
`endif
    S_MSB,
    S_LSB,
    S_CHK
  } state_t;

  state_t          state_q, state_d;
  logic [DCW-1:0]  dcnt_q;
  logic [DW-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [DW-1:0]   sh_q;
  logic [7:0]      byte_d;
  logic            vld_d;
  logic            sel_c, full_c, empty_c, push_c, pop_c, xfer_c;
  logic [7:0]      chk_c;
`ifdef FRAME_SEQ_EN
  logic [7:0]      seq_q;
`endif

  assign sel_c   = sample_vld_i && (dcnt_q == '0);
  assign full_c  = (count_q == CW'(FIFO_DEPTH));
  assign empty_c = (count_q == '0);
  assign push_c  = sel_c && !full_c;
  assign xfer_c  = byte_vld_o && byte_rdy_i;
  assign count_d = count_q + CW'(push_c) - CW'(pop_c);

`ifdef FRAME_SEQ_EN
  assign chk_c = HEADER ^ seq_q ^ sh_q[15:8] ^ sh_q[7:0];
`else
  assign chk_c = HEADER ^ sh_q[15:8] ^ sh_q[7:0];
`endif

  // Decimation phase counter, advanced only by input strobes.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_q <= '0;
    end else if (sample_vld_i) begin
      dcnt_q <= (dcnt_q == DCW'(DECIM - 1)) ? '0 : dcnt_q + DCW'(1);
    end
  end

  // Sample storage; contents are don't-care until written.
  always_ff @(posedge clk_i) begin
    if (push_c) mem[wr_ptr_q] <= sample_i;
  end

  // FIFO pointers, occupancy, full flag and overflow counter.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      fifo_full_o <= 1'b0;
      drop_cnt_o  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q     <= count_d;
      fifo_full_o <= (count_d == CW'(FIFO_DEPTH));
      if (sel_c && full_c && (drop_cnt_o != 16'hFFFF)) drop_cnt_o <= drop_cnt_o + 16'd1;
    end
  end

  // Frame FSM state, registered byte outputs and shadow sample.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_o     <= '0;
      byte_vld_o <= 1'b0;
      sh_q       <= '0;
    end else begin
      state_q    <= state_d;
      byte_o     <= byte_d;
      byte_vld_o <= vld_d;
      if (pop_c) sh_q <= mem[rd_ptr_q];
    end
  end

`ifdef FRAME_SEQ_EN
  // Frame sequence number, bumped when a checksum byte is accepted.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      seq_q <= '0;
    end else if ((state_q == S_CHK) && xfer_c) begin
      seq_q <= seq_q + 8'd1;
    end
  end
`endif

  // Next state and next output byte; the byte for a state is loaded on entry.
  always_comb begin
    state_d = state_q;
    byte_d  = byte_o;
    vld_d   = byte_vld_o;
    pop_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty_c) begin
          pop_c   = 1'b1;
          state_d = S_HDR;
          byte_d  = HEADER;
          vld_d   = 1'b1;
        end
      end
      S_HDR: begin
        if (xfer_c) begin
`ifdef FRAME_SEQ_EN
          state_d = S_SEQ;
          byte_d  = seq_q;
`else
          state_d = S_MSB;
          byte_d  = sh_q[15:8];
`endif
        end
      end
`ifdef FRAME_SEQ_EN
      S_SEQ: begin
        if (xfer_c) begin
          state_d = S_MSB;
          byte_d  = sh_q[15:8];
        end
      end
`endif
      S_MSB: begin
        if (xfer_c) begin
          state_d = S_LSB;
          byte_d  = sh_q[7:0];
        end
      end
      S_LSB: begin
        if (xfer_c) begin
          state_d = S_CHK;
          byte_d  = chk_c;
        end
      end
      S_CHK: begin
        if (xfer_c) begin
          if (!empty_c) begin
            pop_c   = 1'b1;
            state_d = S_HDR;
            byte_d  = HEADER;
            vld_d   = 1'b1;
          end else begin
            state_d = S_IDLE;
            byte_d  = '0;
            vld_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        byte_d  = '0;
        vld_d   = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// Bench for uart_frame_packer: DECIM=1 and DECIM=4 instances share stimulus,
// transferred bytes are compared against frames built from the sample list.
module tb_uart_frame_packer;

  localparam logic [7:0] HDR = 8'hA5;
`ifdef FRAME_SEQ_EN
  localparam int FLEN = 5;
`else
  localparam int FLEN = 4;
`endif

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sample = '0;
  logic        svld = 1'b0;
  logic        rdy = 1'b0;
  logic [7:0]  a_byte, b_byte;
  logic        a_vld, b_vld, a_full, b_full;
  logic [15:0] a_drop, b_drop;

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] got_a[$], got_b[$], exp_a[$], exp_b[$];
  logic [7:0] seq_a = 0, seq_b = 0;
  int         nstrobe = 0;

  always #5 clk_i = ~clk_i;

  uart_frame_packer #(.DECIM(1), .FIFO_DEPTH(8), .HEADER(HDR)) dut_a (
    .clk_i(clk_i), .rst_n(rst_n), .sample_i(sample), .sample_vld_i(svld),
    .byte_o(a_byte), .byte_vld_o(a_vld), .byte_rdy_i(rdy),
    .fifo_full_o(a_full), .drop_cnt_o(a_drop));

  uart_frame_packer #(.DECIM(4), .FIFO_DEPTH(8), .HEADER(HDR)) dut_b (
    .clk_i(clk_i), .rst_n(rst_n), .sample_i(sample), .sample_vld_i(svld),
    .byte_o(b_byte), .byte_vld_o(b_vld), .byte_rdy_i(rdy),
    .fifo_full_o(b_full), .drop_cnt_o(b_drop));

  // Record every byte that transfers at the coming rising edge.
  always @(negedge clk_i) begin
    if (rst_n && rdy && a_vld) got_a.push_back(a_byte);
    if (rst_n && rdy && b_vld) got_b.push_back(b_byte);
  end

  function automatic logic [7:0] fbyte(logic [15:0] s, logic [7:0] sq, int i);
    logic [7:0] hb[5];
`ifdef FRAME_SEQ_EN
    hb = '{HDR, sq, s[15:8], s[7:0], HDR ^ sq ^ s[15:8] ^ s[7:0]};
`else
    hb = '{HDR, s[15:8], s[7:0], HDR ^ s[15:8] ^ s[7:0], sq};
`endif
    return hb[i];
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle strobe; updates the expected frame streams of both instances.
  task automatic strobe(input logic [15:0] s, input bit keep_a);
    sample = s;
    svld   = 1'b1;
    if (keep_a) begin
      for (int i = 0; i < FLEN; i++) exp_a.push_back(fbyte(s, seq_a, i));
      seq_a++;
    end
    if (nstrobe % 4 == 0) begin
      for (int i = 0; i < FLEN; i++) exp_b.push_back(fbyte(s, seq_b, i));
      seq_b++;
    end
    nstrobe++;
    @(posedge clk_i); #1;
    svld = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    svld  = 1'b0;
    rdy   = 1'b0;
    got_a.delete(); got_b.delete(); exp_a.delete(); exp_b.delete();
    seq_a = 0; seq_b = 0; nstrobe = 0;
    repeat (3) @(posedge clk_i);
    #1 rst_n = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic drain();
    int n = 0;
    rdy = 1'b1;
    while ((got_a.size() < exp_a.size() || got_b.size() < exp_b.size()) && n < 3000) begin
      @(posedge clk_i); #1;
      n++;
    end
    repeat (20) @(posedge clk_i);
    #1;
  endtask

  task automatic compare(string tag, logic [15:0] exp_drop_a);
    check({tag, "_a_len"}, 32'(got_a.size()), 32'(exp_a.size()));
    for (int i = 0; i < got_a.size() && i < exp_a.size(); i++)
      check($sformatf("%s_a_byte%0d", tag, i), 32'(got_a[i]), 32'(exp_a[i]));
    check({tag, "_b_len"}, 32'(got_b.size()), 32'(exp_b.size()));
    for (int i = 0; i < got_b.size() && i < exp_b.size(); i++)
      check($sformatf("%s_b_byte%0d", tag, i), 32'(got_b[i]), 32'(exp_b[i]));
    check({tag, "_a_drop"}, 32'(a_drop), 32'(exp_drop_a));
    check({tag, "_b_drop"}, 32'(b_drop), 32'd0);
    check({tag, "_a_full"}, 32'(a_full), 32'd0);
  endtask

  initial begin
    bit found;

    // Reset state
    #2;
    check("rst_byte", 32'(a_byte), 32'd0);
    check("rst_vld", 32'(a_vld), 32'd0);
    do_reset();
    check("rst_full", 32'(a_full), 32'd0);
    check("rst_drop", 32'(a_drop), 32'd0);
    check("rst_b_vld", 32'(b_vld), 32'd0);

    // Single frame, exact latency and back-to-back byte timing
    rdy = 1'b1;
    strobe(16'h1234, 1'b1);
    check("lat_t1_vld", 32'(a_vld), 32'd0);
    @(posedge clk_i); #1;
    check("lat_t2_vld", 32'(a_vld), 32'd1);
    check("lat_t2_hdr", 32'(a_byte), 32'(HDR));
    for (int i = 1; i < FLEN; i++) begin
      @(posedge clk_i); #1;
      check($sformatf("seq_byte%0d", i), 32'(a_byte), 32'(fbyte(16'h1234, 8'd0, i)));
      check($sformatf("seq_vld%0d", i), 32'(a_vld), 32'd1);
    end
    @(posedge clk_i); #1;
    check("idle_vld", 32'(a_vld), 32'd0);
    drain();
    compare("single", 16'd0);

    // Decimation: 8 consecutive strobes 0..7
    do_reset();
    rdy = 1'b1;
    for (int i = 0; i < 8; i++) strobe(16'(i), 1'b1);
    drain();
    check("decim_b_frames", 32'(got_b.size()), 32'(2 * FLEN));
    compare("decim", 16'd0);

    // Stall during MSB
    do_reset();
    rdy = 1'b1;
    strobe(16'h1234, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (a_vld && a_byte == 8'h12) found = 1'b1;
      else begin @(posedge clk_i); #1; end
    end
    check("stall_reach_msb", 32'(found), 32'd1);
    rdy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk_i); #1;
      check($sformatf("stall_byte%0d", i), 32'(a_byte), 32'h12);
      check($sformatf("stall_vld%0d", i), 32'(a_vld), 32'd1);
    end
    rdy = 1'b1;
    @(posedge clk_i); #1;
    check("stall_lsb", 32'(a_byte), 32'h34);
    drain();
    compare("stall", 16'd0);

    // Overflow: shadow holds 1, FIFO holds 8, last 2 dropped
    do_reset();
    rdy = 1'b0;
    for (int i = 0; i < 11; i++) strobe(16'h0100 + 16'(i), i < 9);
    check("ovf_full", 32'(a_full), 32'd1);
    check("ovf_drop", 32'(a_drop), 32'd2);
    rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check($sformatf("ovf_full_hold%0d", i), 32'(a_full), 32'd1);
    end
    repeat (FLEN - 3) @(posedge clk_i);
    #1;
    check("ovf_full_fall", 32'(a_full), 32'd0);
    drain();
    compare("ovf", 16'd2);

    // Asynchronous reset after the MSB transfer, then a fresh frame
    do_reset();
    rdy = 1'b1;
    strobe(16'h1234, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (a_vld && a_byte == 8'h34) found = 1'b1;
      else begin @(posedge clk_i); #1; end
    end
    check("ar_reach_lsb", 32'(found), 32'd1);
    rdy = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_byte", 32'(a_byte), 32'd0);
    check("ar_vld", 32'(a_vld), 32'd0);
    check("ar_full", 32'(a_full), 32'd0);
    check("ar_drop", 32'(a_drop), 32'd0);
    check("ar_b_vld", 32'(b_vld), 32'd0);
    do_reset();
    rdy = 1'b1;
    strobe(16'h00FF, 1'b1);
    drain();
    compare("after_rst", 16'd0);

    // Random samples, random but never twice-low ready, no overflow possible
    do_reset();
    for (int k = 0; k < 30; k++) begin
      int gap;
      gap = $urandom_range(12, 20);
      rdy = 1'b1;
      strobe(16'($urandom), 1'b1);
      for (int c = 0; c < gap; c++) begin
        rdy = ($urandom_range(0, 1) == 1) || (c % 2 == 0);
        @(posedge clk_i); #1;
      end
    end
    drain();
    compare("rand", 16'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
